// File: rtl/gray_ptr_sync_multi.sv
// ============================================================================
// Module   : gray_ptr_sync_multi
// Purpose  : Multi-channel Gray-pointer synchroniser for the destination side
//            of async FIFOs. Each channel passes its Gray pointer through a
//            STAGES-deep flop chain. It then produces a registered binary copy,
//            a change pulse and a sticky illegal-transition flag. A shared
//            warm-up counter raises sync_vld once the chains hold only
//            post-reset samples.
// Ports    : wclk      - destination clock (rising edge)
//            wrst      - synchronous active-high reset
//            rptr_gray - NCH packed Gray pointers, channel c at [c*(ASIZE+1) +: ASIZE+1]
//            err_clr   - per-channel clear of gray_err (a set in the same cycle wins)
//            sync_gray - last chain stage per channel
//            sync_bin  - registered binary of sync_gray
//            ptr_chg   - one-cycle pulse when sync_bin changes (gated by sync_vld)
//            gray_err  - sticky multi-bit Gray transition flag
//            sync_vld  - warm-up complete
//            sync_delta- (SYNC_DELTA_EN only) sync_bin increment, aligned with ptr_chg
// Options  : define SYNC_DELTA_EN to add the sync_delta output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_ptr_sync_multi #(
  parameter int ASIZE  = 4,
  parameter int NCH    = 1,
  parameter int STAGES = 2
) (
  input  logic                      wclk,
  input  logic                      wrst,
  input  logic [NCH*(ASIZE+1)-1:0]  rptr_gray,
  input  logic [NCH-1:0]            err_clr,
  output logic [NCH*(ASIZE+1)-1:0]  sync_gray,
  output logic [NCH*(ASIZE+1)-1:0]  sync_bin,
  output logic [NCH-1:0]            ptr_chg,
  output logic [NCH-1:0]            gray_err,
  output logic                      sync_vld
`ifdef SYNC_DELTA_EN
  ,
  output logic [NCH*(ASIZE+1)-1:0]  sync_delta
`endif
);

  localparam int c_W  = ASIZE + 1;
  localparam int c_CW = $clog2(STAGES + 2);
  localparam logic [c_CW-1:0] c_VLD_CNT = c_CW'(STAGES + 1);

  if (STAGES < 2) begin : g_stage_check
    $error("gray_ptr_sync_multi: STAGES must be >= 2");
  end

  // Warm-up: STAGES edges fill the chain, one more registers sync_bin.
  logic [c_CW-1:0] r_cnt;
  logic            w_vld;

  assign w_vld    = (r_cnt == c_VLD_CNT);
  assign sync_vld = w_vld;

  always_ff @(posedge wclk) begin
    if (wrst) begin
      r_cnt <= '0;
    end else if (!w_vld) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [c_W-1:0] r_chain [STAGES];
    logic [c_W-1:0] r_prev;
    logic [c_W-1:0] r_bin;
    logic           r_chg;
    logic           r_err;
    logic [c_W-1:0] w_sg;
    logic [c_W-1:0] w_bin;
    logic [c_W-1:0] w_diff;
    logic [c_W-1:0] w_diff_m1;
    logic           w_multi;
    logic           w_new;

    assign w_sg      = r_chain[STAGES-1];
    assign w_diff    = w_sg ^ r_prev;
    assign w_diff_m1 = w_diff - c_W'(1);
    // Clearing the lowest set bit leaves a non-zero result only if 2+ bits differ.
    assign w_multi   = |(w_diff & w_diff_m1);
    assign w_new     = (w_bin != r_bin);

    // bin[i] is the XOR of all Gray bits from i upward.
    always_comb begin
      w_bin = '0;
      for (int i = 0; i < c_W; i++) begin
        w_bin[i] = ^(w_sg >> i);
      end
    end

    always_ff @(posedge wclk) begin
      if (wrst) begin
        for (int k = 0; k < STAGES; k++) begin
          r_chain[k] <= '0;
        end
        r_prev <= '0;
        r_bin  <= '0;
        r_chg  <= 1'b0;
        r_err  <= 1'b0;
      end else begin
        r_chain[0] <= rptr_gray[c*c_W +: c_W];
        for (int k = 1; k < STAGES; k++) begin
          r_chain[k] <= r_chain[k-1];
        end
        r_prev <= w_sg;
        r_bin  <= w_bin;
        r_chg  <= w_vld && w_new;
        // Set has priority over clear so a coincident fault is never lost.
        r_err  <= (r_err && !err_clr[c]) || (w_vld && w_multi);
      end
    end

    assign sync_gray[c*c_W +: c_W] = w_sg;
    assign sync_bin[c*c_W +: c_W]  = r_bin;
    assign ptr_chg[c]              = r_chg;
    assign gray_err[c]             = r_err;

`ifdef SYNC_DELTA_EN
    logic [c_W-1:0] r_delta;

    always_ff @(posedge wclk) begin
      if (wrst) begin
        r_delta <= '0;
      end else if (w_vld && w_new) begin
        r_delta <= w_bin - r_bin;  // modular subtraction handles wrap
      end else begin
        r_delta <= '0;
      end
    end

    assign sync_delta[c*c_W +: c_W] = r_delta;
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_gray_ptr_sync_multi.sv
// ============================================================================
// Module   : tb_gray_ptr_sync_multi
// Purpose  : Scoreboard bench for gray_ptr_sync_multi (ASIZE=4, NCH=3,
//            STAGES=2). Stimulus queues expected values tagged with the edge
//            count at which they must hold. A monitor compares them on the
//            falling edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gray_ptr_sync_multi;

  localparam int ASIZE  = 4;
  localparam int NCH    = 3;
  localparam int STAGES = 2;
  localparam int W      = ASIZE + 1;

  localparam int SEL_SG  = 0;
  localparam int SEL_SB  = 1;
  localparam int SEL_CHG = 2;
  localparam int SEL_ERR = 3;
  localparam int SEL_VLD = 4;
  localparam int SEL_DLT = 5;

  logic               wclk = 1'b0;
  logic               wrst;
  logic [NCH*W-1:0]   rptr_gray;
  logic [NCH-1:0]     err_clr;
  logic [NCH*W-1:0]   sync_gray;
  logic [NCH*W-1:0]   sync_bin;
  logic [NCH-1:0]     ptr_chg;
  logic [NCH-1:0]     gray_err;
  logic               sync_vld;
`ifdef SYNC_DELTA_EN
  logic [NCH*W-1:0]   sync_delta;
`endif

  gray_ptr_sync_multi #(.ASIZE(ASIZE), .NCH(NCH), .STAGES(STAGES)) dut (
    .wclk      (wclk),
    .wrst      (wrst),
    .rptr_gray (rptr_gray),
    .err_clr   (err_clr),
    .sync_gray (sync_gray),
    .sync_bin  (sync_bin),
    .ptr_chg   (ptr_chg),
    .gray_err  (gray_err),
    .sync_vld  (sync_vld)
`ifdef SYNC_DELTA_EN
    ,
    .sync_delta(sync_delta)
`endif
  );

  always #5 wclk = ~wclk;

  int edge_n = 0;
  always @(posedge wclk) edge_n <= edge_n + 1;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] exp;
    string       nm;
  } sb_t;

  sb_t sb_q[$];
  int  total = 0;
  int  bad   = 0;

  function automatic logic [NCH*W-1:0] pk(logic [W-1:0] g0, logic [W-1:0] g1, logic [W-1:0] g2);
    return {g2, g1, g0};
  endfunction

  function automatic logic [31:0] get_act(int sel);
    case (sel)
      SEL_SG:  return 32'(sync_gray);
      SEL_SB:  return 32'(sync_bin);
      SEL_CHG: return 32'(ptr_chg);
      SEL_ERR: return 32'(gray_err);
      SEL_VLD: return 32'(sync_vld);
`ifdef SYNC_DELTA_EN
      SEL_DLT: return 32'(sync_delta);
`endif
      default: return 32'hdead_beef;
    endcase
  endfunction

  // Queue an expectation that must hold after edge (current + d).
  task automatic exp_at(int d, int sel, logic [31:0] v, string nm);
    sb_t e;
    e.cyc = edge_n + d;
    e.sel = sel;
    e.exp = v;
    e.nm  = nm;
    sb_q.push_back(e);
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge wclk);
  endtask

  // Monitor: compare every queued expectation whose edge has arrived.
  always begin
    @(negedge wclk);
    #1;
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].cyc == edge_n) begin
        logic [31:0] act;
        act = get_act(sb_q[i].sel);
        total++;
        if (act !== sb_q[i].exp) begin
          bad++;
          $display("FAIL %s @edge %0d: got %0h want %0h", sb_q[i].nm, edge_n, act, sb_q[i].exp);
        end
        sb_q.delete(i);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wrst      = 1'b1;
    err_clr   = '0;
    rptr_gray = pk(5'b00111, 5'b0, 5'b0);

    // 1: reset, then warm-up latency
    cyc(3);
    exp_at(0, SEL_SG,  0, "rst_sync_gray");
    exp_at(0, SEL_SB,  0, "rst_sync_bin");
    exp_at(0, SEL_CHG, 0, "rst_ptr_chg");
    exp_at(0, SEL_ERR, 0, "rst_gray_err");
    exp_at(0, SEL_VLD, 0, "rst_sync_vld");
    wrst = 1'b0;
    exp_at(1, SEL_SG,  0, "t1_sg_edge1");
    exp_at(2, SEL_SG,  32'(pk(5'b00111, 0, 0)), "t1_sg_edge2");
    exp_at(2, SEL_VLD, 0, "t1_vld_edge2");
    exp_at(3, SEL_SB,  5, "t1_bin_edge3");
    exp_at(3, SEL_VLD, 1, "t1_vld_edge3");
    exp_at(3, SEL_CHG, 0, "t1_chg_warmup");
    exp_at(3, SEL_ERR, 0, "t1_err_warmup");
    cyc(5);

    // 2: single increment 5 -> 6 on channel 0
    rptr_gray = pk(5'b00101, 0, 0);
    exp_at(2, SEL_SB,  5, "t2_bin_before");
    exp_at(3, SEL_SB,  6, "t2_bin");
    exp_at(3, SEL_CHG, 3'b001, "t2_chg_pulse");
    exp_at(4, SEL_CHG, 0, "t2_chg_end");
    exp_at(4, SEL_ERR, 0, "t2_err");
`ifdef SYNC_DELTA_EN
    exp_at(3, SEL_DLT, 1, "t2_delta");
    exp_at(4, SEL_DLT, 0, "t2_delta_end");
`endif
    cyc(6);

    // 3: move to bin 31 (multi-bit jump, flag cleared afterwards), then wrap
    rptr_gray = pk(5'b10000, 0, 0);
    exp_at(3, SEL_SB,  31, "t3_bin31");
    exp_at(3, SEL_ERR, 3'b001, "t3_setup_err");
    cyc(4);
    err_clr = 3'b001;
    cyc(1);
    err_clr = '0;
    exp_at(0, SEL_ERR, 0, "t3_err_cleared");
    cyc(2);
    rptr_gray = pk(5'b00000, 0, 0);
    exp_at(2, SEL_SB,  31, "t3_bin_before_wrap");
    exp_at(3, SEL_SB,  0, "t3_bin_wrap");
    exp_at(3, SEL_CHG, 3'b001, "t3_chg_wrap");
    exp_at(4, SEL_ERR, 0, "t3_err_wrap");
`ifdef SYNC_DELTA_EN
    exp_at(3, SEL_DLT, 1, "t3_delta_wrap");
`endif
    cyc(6);

    // 4: illegal jump, set-wins-over-clear, then clear alone
    rptr_gray = pk(5'b00011, 0, 0);
    exp_at(2, SEL_ERR, 0, "t4_err_pre");
    exp_at(3, SEL_ERR, 3'b001, "t4_err_set");
    exp_at(5, SEL_ERR, 3'b001, "t4_err_sticky");
    cyc(6);
    rptr_gray = pk(5'b00110, 0, 0);
    cyc(2);
    err_clr = 3'b001;
    exp_at(1, SEL_ERR, 3'b001, "t4_set_wins");
    exp_at(1, SEL_SB,  4, "t4_bin4");
    cyc(1);
    err_clr = '0;
    cyc(2);
    err_clr = 3'b001;
    exp_at(1, SEL_ERR, 0, "t4_clr");
    cyc(1);
    err_clr = '0;
    cyc(3);

    // 5: channel independence
    rptr_gray = pk(5'b00110, 5'b00001, 0);
    exp_at(3, SEL_CHG, 3'b010, "t5_chg_ch1");
    exp_at(3, SEL_SB,  32'(pk(5'd4, 5'd1, 5'd0)), "t5_bin_all");
    exp_at(4, SEL_CHG, 0, "t5_chg_end");
    exp_at(4, SEL_ERR, 0, "t5_err_none");
    cyc(6);
    rptr_gray = pk(5'b00110, 5'b00001, 5'b00011);
    exp_at(3, SEL_ERR, 3'b100, "t5_err_ch2");
    exp_at(3, SEL_CHG, 3'b100, "t5_chg_ch2");
    cyc(6);

    // 6: mid-run reset with sync_vld=1 and gray_err[2]=1
    wrst = 1'b1;
    exp_at(0, SEL_ERR, 3'b100, "t6_err_before");
    exp_at(1, SEL_SG,  0, "t6_rst_sg");
    exp_at(1, SEL_SB,  0, "t6_rst_sb");
    exp_at(1, SEL_CHG, 0, "t6_rst_chg");
    exp_at(1, SEL_ERR, 0, "t6_rst_err");
    exp_at(1, SEL_VLD, 0, "t6_rst_vld");
    cyc(1);
    wrst = 1'b0;
    exp_at(2, SEL_SG,  32'(pk(5'b00110, 5'b00001, 5'b00011)), "t6_sg");
    exp_at(2, SEL_VLD, 0, "t6_vld_early");
    exp_at(3, SEL_VLD, 1, "t6_vld_back");
    exp_at(3, SEL_SB,  32'(pk(5'd4, 5'd1, 5'd2)), "t6_bin");
    exp_at(3, SEL_CHG, 0, "t6_chg_warmup");
    exp_at(4, SEL_ERR, 0, "t6_err_warmup");
    cyc(8);

    if (sb_q.size() != 0) begin
      bad += sb_q.size();
      total += sb_q.size();
      $display("FAIL unchecked_entries: got %0d want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
